// File: rtl/lc4_fetch_delay_line_pkg.sv
`default_nettype none
// ============================================================================
// Module : lc4_mem_pkg
// Brief  : Shared word type, default latency and delay clamp helper for the
//          LC4 memory read-latency model.
// Rev    : 1.0  initial release
// ============================================================================
package lc4_mem_pkg;

    localparam int LC4_WORD_W        = 16;
    localparam int LC4_DEFAULT_DELAY = 8;

    typedef logic [LC4_WORD_W-1:0] lc4_word_t;

    // Requests beyond the physical pipeline depth saturate at the deepest tap.
    function automatic int clamp_delay(input int req, input int max_delay);
        return (req > max_delay) ? max_delay : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc4_fetch_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module : lc4_fetch_delay_line_if
// Brief  : Read-channel bundle between the block-RAM side and the delay line.
//          master : drives gwe, cfg_load, delay_cfg, in_valid, in_data and
//                   observes out_valid, out_data, cur_delay, busy
//          slave  : the delay line itself
// Rev    : 1.0  initial release
// ============================================================================
interface lc4_fetch_delay_line_if
    import lc4_mem_pkg::*;
#(
    parameter int WIDTH     = LC4_WORD_W,
    parameter int NCH       = 2,
    parameter int MAX_DELAY = LC4_DEFAULT_DELAY
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    logic                 gwe;
    logic                 cfg_load;
    logic [DW-1:0]        delay_cfg;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH*WIDTH-1:0] out_data;
    logic [DW-1:0]        cur_delay;
    logic                 busy;

    modport master (
        output gwe, cfg_load, delay_cfg, in_valid, in_data,
        input  out_valid, out_data, cur_delay, busy
    );

    modport slave (
        input  gwe, cfg_load, delay_cfg, in_valid, in_data,
        output out_valid, out_data, cur_delay, busy
    );
endinterface
`default_nettype wire

// File: rtl/lc4_delay_stage_chain.sv
`default_nettype none
// ============================================================================
// Module : lc4_delay_stage_chain
// Brief  : One channel's MAX_DELAY-deep {valid,data} shift register with a
//          run-time selectable output tap (delay 0 = combinational bypass).
// Ports  : clk, rst (async, active-low), gwe (advance), flush (clear valids),
//          in_valid/in_data, delay (tap select), out_valid/out_data
// Rev    : 1.0  initial release
// ============================================================================
module lc4_delay_stage_chain #(
    parameter int WIDTH     = 16,
    parameter int MAX_DELAY = 8,
    parameter int DW        = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             gwe,
    input  wire logic             flush,
    input  wire logic             in_valid,
    input  wire logic [WIDTH-1:0] in_data,
    input  wire logic [DW-1:0]    delay,
    output logic                  out_valid,
    output logic      [WIDTH-1:0] out_data
);
    logic [MAX_DELAY-1:0] r_valid;
    logic [WIDTH-1:0]     r_data [MAX_DELAY];
    logic                 w_tap_valid;
    logic [WIDTH-1:0]     w_tap_data;

    // Data keeps shifting during a flush; only the valids are cleared, and
    // the output mask hides whatever payload is left behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                r_data[k] <= '0;
            end
        end else if (gwe) begin
            r_valid[0] <= in_valid & ~flush;
            r_data[0]  <= in_data;
            for (int k = 1; k < MAX_DELAY; k++) begin
                r_valid[k] <= r_valid[k-1] & ~flush;
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    // Tap stage delay-1; delay 0 falls through to the live input.
    always_comb begin
        w_tap_valid = in_valid;
        w_tap_data  = in_data;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (delay == DW'(k + 1)) begin
                w_tap_valid = r_valid[k];
                w_tap_data  = r_data[k];
            end
        end
    end

    assign out_valid = w_tap_valid;
    assign out_data  = w_tap_valid ? w_tap_data : '0;

endmodule
`default_nettype wire

// File: rtl/lc4_fetch_delay_line.sv
`default_nettype none
// ============================================================================
// Module : lc4_fetch_delay_line
// Brief  : Run-time configurable read-latency model for NCH memory channels.
//          Holds the shared latency register, the post-reconfigure settle
//          counter and the config clamp; one stage chain per channel.
// Ports  : clk, rst (async, active-low), bus (lc4_fetch_delay_line_if.slave)
// Rev    : 1.0  initial release
// ============================================================================
module lc4_fetch_delay_line
    import lc4_mem_pkg::*;
#(
    parameter int WIDTH     = LC4_WORD_W,
    parameter int NCH       = 2,
    parameter int MAX_DELAY = LC4_DEFAULT_DELAY
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lc4_fetch_delay_line_if.slave bus
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    logic [DW-1:0]        r_cur_delay;
    logic [DW-1:0]        r_settle;
    logic [DW-1:0]        w_cfg_clamped;
    logic                 w_flush;
    logic [NCH-1:0]       w_out_valid;
    logic [NCH*WIDTH-1:0] w_out_data;

    assign w_cfg_clamped = DW'(clamp_delay(int'(bus.delay_cfg), MAX_DELAY));
    assign w_flush       = bus.gwe & bus.cfg_load;

    // A reload always restarts the settle count, even when the value is
    // unchanged or a previous refill is still in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_delay <= DW'(MAX_DELAY);
            r_settle    <= '0;
        end else if (bus.gwe) begin
            if (bus.cfg_load) begin
                r_cur_delay <= w_cfg_clamped;
                r_settle    <= w_cfg_clamped;
            end else if (r_settle != '0) begin
                r_settle <= r_settle - DW'(1);
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        lc4_delay_stage_chain #(
            .WIDTH     (WIDTH),
            .MAX_DELAY (MAX_DELAY),
            .DW        (DW)
        ) u_chain (
            .clk       (clk),
            .rst       (rst),
            .gwe       (bus.gwe),
            .flush     (w_flush),
            .in_valid  (bus.in_valid[c]),
            .in_data   (bus.in_data[c*WIDTH +: WIDTH]),
            .delay     (r_cur_delay),
            .out_valid (w_out_valid[c]),
            .out_data  (w_out_data[c*WIDTH +: WIDTH])
        );
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.cur_delay = r_cur_delay;
    assign bus.busy      = (r_settle != '0);

endmodule
`default_nettype wire

// File: tb/tb_lc4_fetch_delay_line.sv
`default_nettype none
// ============================================================================
// Module : tb_lc4_fetch_delay_line
// Brief  : Directed, table-driven bench for lc4_fetch_delay_line (2 x 16-bit
//          channels, MAX_DELAY 8) plus hand-written reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lc4_fetch_delay_line;
    import lc4_mem_pkg::*;

    typedef struct {
        logic       gwe;
        logic       cfg;
        logic [3:0] dcfg;
        logic [1:0] iv;
        lc4_word_t  d1;
        lc4_word_t  d0;
        logic [1:0] eov;
        lc4_word_t  e1;
        lc4_word_t  e0;
        logic [3:0] ecd;
        logic       eb;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    lc4_fetch_delay_line_if #(.WIDTH(16), .NCH(2), .MAX_DELAY(8)) bus ();

    lc4_fetch_delay_line #(.WIDTH(16), .NCH(2), .MAX_DELAY(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic g, input logic cf, input logic [3:0] dc,
                       input logic [1:0] iv, input lc4_word_t d1, input lc4_word_t d0,
                       input logic [1:0] eov, input lc4_word_t e1, input lc4_word_t e0,
                       input logic [3:0] ecd, input logic eb);
        vec_t v;
        v.gwe = g;  v.cfg = cf; v.dcfg = dc; v.iv = iv; v.d1 = d1; v.d0 = d0;
        v.eov = eov; v.e1 = e1; v.e0 = e0; v.ecd = ecd; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic g, input logic cf, input logic [3:0] dc,
                         input logic [1:0] iv, input logic [31:0] d);
        bus.gwe       = g;
        bus.cfg_load  = cf;
        bus.delay_cfg = dc;
        bus.in_valid  = iv;
        bus.in_data   = d;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // ---- held reset with both channels presenting valid data ----
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 2'b11, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", {30'd0, bus.out_valid}, 32'd0);
        check("rst out_data", bus.out_data, 32'd0);
        check("rst cur_delay", {28'd0, bus.cur_delay}, 32'd8);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- vector table ----
        repeat (8) add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        // default D=8: ch0 at edge 1 -> visible after edge 8; ch1 at edge 3 -> after edge 10
        add(1, 0, 0, 2'b01, 16'h0000, 16'h1234, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b10, 16'hBEEF, 16'h0000, 2'b00, 0, 0, 8, 0);
        repeat (4) add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b01, 16'h0000, 16'h1234, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b10, 16'hBEEF, 16'h0000, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        // gwe stall mid-stream: junk and cfg_load while gwe=0 are ignored
        add(1, 0, 0, 2'b01, 16'h0000, 16'hA5A5, 2'b00, 0, 0, 8, 0);
        repeat (2) add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        repeat (4) add(0, 0, 0, 2'b11, 16'hFFFF, 16'hFFFF, 2'b00, 0, 0, 8, 0);
        add(0, 1, 3, 2'b11, 16'hFFFF, 16'hFFFF, 2'b00, 0, 0, 8, 0);
        repeat (4) add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b01, 16'h0000, 16'hA5A5, 8, 0);
        add(0, 0, 0, 2'b00, 0, 0, 2'b01, 16'h0000, 16'hA5A5, 8, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 8, 0);
        // reconfigure to 3 with 4 words in flight; cfg-cycle word discarded
        add(1, 0, 0, 2'b01, 0, 16'h0101, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b01, 0, 16'h0102, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b01, 0, 16'h0103, 2'b00, 0, 0, 8, 0);
        add(1, 0, 0, 2'b01, 0, 16'h0104, 2'b00, 0, 0, 8, 0);
        add(1, 1, 3, 2'b01, 0, 16'hDEAD, 2'b00, 0, 0, 3, 1);
        add(1, 0, 0, 2'b01, 0, 16'h0042, 2'b00, 0, 0, 3, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 3, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b01, 0, 16'h0042, 3, 0);
        repeat (3) add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 3, 0);
        // bypass and masking at D=0, then clamp 12 -> 8
        add(1, 1, 0, 2'b01, 0, 16'h7777, 2'b01, 0, 16'h7777, 0, 0);
        add(1, 0, 0, 2'b10, 16'h1111, 16'h5555, 2'b10, 16'h1111, 0, 0, 0);
        add(1, 1, 12, 2'b00, 0, 0, 2'b00, 0, 0, 8, 1);
        // reload while busy restarts; word accepted before it is flushed
        add(1, 0, 0, 2'b01, 0, 16'h0BAD, 2'b00, 0, 0, 8, 1);
        add(1, 1, 2, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 0);
        // reload with the same value still flushes
        add(1, 0, 0, 2'b01, 0, 16'h00C1, 2'b00, 0, 0, 2, 0);
        add(1, 1, 2, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 0);
        // D=1: word visible right after its accept edge
        add(1, 1, 1, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1);
        add(1, 0, 0, 2'b01, 0, 16'h00D1, 2'b01, 0, 16'h00D1, 1, 0);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0);
        // leave D=2 for the reset sequence
        add(1, 1, 2, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 1);
        add(1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].gwe, vecs[i].cfg, vecs[i].dcfg, vecs[i].iv, {vecs[i].d1, vecs[i].d0});
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), {30'd0, bus.out_valid}, {30'd0, vecs[i].eov});
            check($sformatf("v%0d out_data", i), bus.out_data, {vecs[i].e1, vecs[i].e0});
            check($sformatf("v%0d cur_delay", i), {28'd0, bus.cur_delay}, {28'd0, vecs[i].ecd});
            check($sformatf("v%0d busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].eb});
        end

        // ---- asynchronous reset mid-stream at D=2 ----
        drive(1'b1, 1'b0, 4'd0, 2'b01, 32'h0000_00E1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'd0, 2'b00, 32'h0);
        @(posedge clk);
        #1;
        check("pre-rst out_valid", {30'd0, bus.out_valid}, 32'd1);
        check("pre-rst out_data", bus.out_data, 32'h0000_00E1);
        #3;
        rst = 1'b0;
        #1;
        check("async rst out_valid", {30'd0, bus.out_valid}, 32'd0);
        check("async rst out_data", bus.out_data, 32'd0);
        check("async rst cur_delay", {28'd0, bus.cur_delay}, 32'd8);
        check("async rst busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst e%0d out_valid", e), {30'd0, bus.out_valid}, 32'd0);
            check($sformatf("post-rst e%0d out_data", e), bus.out_data, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
